// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: services Z80 cartridge reads behind the MSX mapper.
// A falling rd_n on a selected cartridge cycle either hits the one-entry
// last-address cache or fetches the byte from external memory. While the
// fetch is outstanding, WAIT is held low. A fetch that gets no answer
// within TIMEOUT_CYC cycles is abandoned and returns 8'hFF.
module cart_rom_fetch #(
  parameter int ADDR_W      = 23,
  parameter int TIMEOUT_CYC = 64,
  parameter int CACHE_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cart_ena,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              rd_n,
  input  logic              cache_inv,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        cdout,
  output logic              busdir,
  output logic              wait_n,
  output logic              timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_rd_n_q;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_raddr;
  logic [7:0]        r_cdout;
  logic              r_busdir;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cache_valid;
  logic [ADDR_W-1:0] r_cache_addr;
  logic [7:0]        r_cache_data;

  logic w_start;
  logic w_hit;
  logic w_expire;
  logic w_release;
  logic w_wait_n;

  assign w_start   = cart_ena & ~rd_n & r_rd_n_q;
  assign w_hit     = (CACHE_EN != 0) && r_cache_valid && (mem_addr == r_cache_addr);
  assign w_expire  = (r_cnt == CNT_LAST);
  assign w_release = rd_n | ~cart_ena;

  // Next-state decode and combinational WAIT
  always_comb begin
    w_state_nxt = r_state;
    w_wait_n    = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_hit) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_FETCH;
            w_wait_n    = 1'b0;
          end
        end
      end
      S_FETCH: begin
        w_wait_n = 1'b0;
        if (mem_ready || w_expire) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_release) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request, bus data, cache and error-flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_n_q      <= 1'b1;
      r_mem_req     <= 1'b0;
      r_mem_raddr   <= '0;
      r_cdout       <= '1;
      r_busdir      <= 1'b0;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
      r_cache_valid <= 1'b0;
      r_cache_addr  <= '0;
      r_cache_data  <= '0;
    end else begin
      r_rd_n_q <= rd_n;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_hit) begin
              r_cdout  <= r_cache_data;
              r_busdir <= 1'b1;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_raddr <= mem_addr;
              r_cnt       <= '0;
            end
          end
        end
        S_FETCH: begin
          // Data arriving on the expiry cycle takes precedence over the timeout
          if (mem_ready) begin
            r_mem_req     <= 1'b0;
            r_cdout       <= mem_rdata;
            r_busdir      <= 1'b1;
            r_cache_addr  <= r_mem_raddr;
            r_cache_data  <= mem_rdata;
            r_cache_valid <= 1'b1;
          end else if (w_expire) begin
            r_mem_req <= 1'b0;
            r_cdout   <= 8'hFF;
            r_busdir  <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_release) r_busdir <= 1'b0;
        end
        default: ;
      endcase
      // Placed last so an invalidate beats a same-cycle fill
      if (cache_inv) r_cache_valid <= 1'b0;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_raddr = r_mem_raddr;
  assign cdout     = r_cdout;
  assign busdir    = r_busdir;
  assign wait_n    = w_wait_n;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Bench for cart_rom_fetch: the stimulus issues Z80 reads and answers as the
// memory. Each expected bus response goes onto a scoreboard queue. A monitor
// pops one entry each time busdir rises and checks data, latency, WAIT and
// request durations, and the sticky timeout flag.
`timescale 1ns/1ps
module tb_cart_rom_fetch;

  localparam int AW = 23;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          cart_ena;
  logic [AW-1:0] mem_addr;
  logic          rd_n;
  logic          cache_inv;
  logic          mem_req;
  logic [AW-1:0] mem_raddr;
  logic          mem_ready;
  logic [7:0]    mem_rdata;
  logic [7:0]    cdout;
  logic          busdir;
  logic          wait_n;
  logic          timeout;

  cart_rom_fetch #(.ADDR_W(AW), .TIMEOUT_CYC(TO), .CACHE_EN(1)) dut (
    .clk(clk), .reset(reset), .cart_ena(cart_ena), .mem_addr(mem_addr),
    .rd_n(rd_n), .cache_inv(cache_inv), .mem_req(mem_req),
    .mem_raddr(mem_raddr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cdout(cdout), .busdir(busdir), .wait_n(wait_n), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         lat;
    int         waits;
    int         reqs;
    logic       to;
    time        t0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: the cache entry and the sticky error flag
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [7:0]    m_data  = '0;
  logic          m_to    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    if (a == 23'h004123) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h3C;
  endfunction

  // Monitor: every rising busdir is a response that must match the queue head
  exp_t e;
  int   cw = 0;
  int   cr = 0;
  logic prev_bd = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cw = 0; cr = 0; prev_bd = 1'b0;
      end else begin
        if (!wait_n) cw++;
        if (mem_req) cr++;
        if (busdir && !prev_bd) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_output: busdir rose, cdout=%0h, nothing expected at %0t", cdout, $time);
          end else begin
            e = sb.pop_front();
            chk("cdout", 32'(cdout), 32'(e.data));
            chk("latency", 32'(($time - e.t0) / 10), 32'(e.lat));
            chk("wait_cycles", 32'(cw), 32'(e.waits));
            chk("req_cycles", 32'(cr), 32'(e.reqs));
            chk("timeout_flag", 32'(timeout), 32'(e.to));
          end
          cw = 0; cr = 0;
        end
        prev_bd = busdir;
      end
    end
  end

  // One read cycle. lat = FETCH cycle carrying mem_ready (0: never answer).
  // inv_evt pulses cache_inv on the start cycle of a hit or the fill cycle of a miss.
  task automatic do_read(input logic [AW-1:0] a, input int lat, input bit cart,
                         input bit abort, input bit inv_evt);
    exp_t x;
    logic [7:0] d;
    bit hit;
    @(posedge clk); #1;
    cart_ena = cart; mem_addr = a; rd_n = 1'b0;
    x.t0 = $time;
    if (!cart) begin
      for (int unsigned i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("nocart_req", 32'(mem_req), 32'd0);
        chk("nocart_busdir", 32'(busdir), 32'd0);
        chk("nocart_wait_n", 32'(wait_n), 32'd1);
      end
      @(posedge clk); #1; rd_n = 1'b1;
      return;
    end
    hit = m_valid && (m_addr == a);
    if (hit) begin
      x.data = m_data; x.lat = 1; x.waits = 0; x.reqs = 0; x.to = m_to;
      sb.push_back(x);
      cache_inv = inv_evt;
      if (inv_evt) m_valid = 1'b0;
      @(posedge clk); #1; cache_inv = 1'b0;
    end else begin
      d = mem_byte(a);
      if (lat > 0) begin
        x.data = d; x.lat = lat + 1; x.waits = lat + 1; x.reqs = lat; x.to = m_to;
        m_valid = !inv_evt; m_addr = a; m_data = d;
      end else begin
        m_to = 1'b1;
        x.data = 8'hFF; x.lat = TO + 1; x.waits = TO + 1; x.reqs = TO; x.to = 1'b1;
      end
      sb.push_back(x);
      @(posedge clk); #1;
      if (abort) begin rd_n = 1'b1; cart_ena = 1'b0; end
      @(negedge clk);
      chk("mem_raddr", 32'(mem_raddr), 32'(a));
      #4;
      if (lat > 0) begin
        repeat (lat - 1) begin @(posedge clk); #1; end
        mem_ready = 1'b1; mem_rdata = d; cache_inv = inv_evt;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = 8'($urandom); cache_inv = 1'b0;
      end else begin
        repeat (TO) begin @(posedge clk); #1; end
      end
    end
    @(posedge clk); #1;
    rd_n = 1'b1; cart_ena = 1'($urandom);
    @(posedge clk); #1;
  endtask

  // Idle gap, optionally with a stray mem_ready or a cache invalidate
  task automatic gap(input bit inv, input bit rdy);
    @(posedge clk); #1;
    rd_n = 1'b1; cache_inv = inv; mem_ready = rdy; mem_rdata = 8'($urandom);
    if (inv) m_valid = 1'b0;
    @(posedge clk); #1;
    cache_inv = 1'b0; mem_ready = 1'b0;
  endtask

  logic [AW-1:0] pool [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pool[0] = 23'h004123; pool[1] = 23'h000010;
    pool[2] = 23'h7FFFFF; pool[3] = 23'h012345;
    reset = 1'b1; cart_ena = 1'b0; mem_addr = '0; rd_n = 1'b1;
    cache_inv = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    @(posedge clk); @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_cdout", 32'(cdout), 32'hFF);
    chk("rst_busdir", 32'(busdir), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_wait_n", 32'(wait_n), 32'd1);
    @(posedge clk); #1; reset = 1'b0;
    gap(1'b0, 1'b1);

    do_read(23'h004123, 5, 1'b1, 1'b0, 1'b0);   // miss, 5-cycle memory
    gap(1'b0, 1'b0);
    do_read(23'h004123, 3, 1'b1, 1'b0, 1'b0);   // hit
    gap(1'b1, 1'b0);
    do_read(23'h004123, 2, 1'b1, 1'b0, 1'b0);   // miss after invalidate
    gap(1'b0, 1'b0);
    do_read(23'h004123, 2, 1'b1, 1'b0, 1'b1);   // hit using pre-invalidate entry
    gap(1'b0, 1'b0);
    do_read(23'h004123, 4, 1'b1, 1'b0, 1'b1);   // miss; fill cancelled by invalidate
    gap(1'b0, 1'b0);
    do_read(23'h004123, 1, 1'b1, 1'b0, 1'b0);   // miss again
    gap(1'b0, 1'b0);
    do_read(23'h00C000, 3, 1'b0, 1'b0, 1'b0);   // cart_ena low: ignored
    gap(1'b0, 1'b0);
    do_read(23'h000777, 0, 1'b1, 1'b0, 1'b0);   // timeout
    gap(1'b0, 1'b1);
    do_read(23'h000778, TO, 1'b1, 1'b0, 1'b0);  // ready on expiry cycle: data wins
    gap(1'b0, 1'b0);
    do_read(23'h000779, 3, 1'b1, 1'b1, 1'b0);   // rd_n rises mid-fetch
    gap(1'b0, 1'b0);

    for (int unsigned i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      int lat;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 3)];
      lat = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 8));
      do_read(a, lat, $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
              (lat > 0) && ($urandom_range(0, 7) == 0));
      gap($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a fetch
    @(posedge clk); #1;
    cart_ena = 1'b1; mem_addr = 23'h004200; rd_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1; rd_n = 1'b1; cart_ena = 1'b0;
    m_valid = 1'b0; m_to = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstfetch_mem_req", 32'(mem_req), 32'd0);
    chk("rstfetch_busdir", 32'(busdir), 32'd0);
    chk("rstfetch_wait_n", 32'(wait_n), 32'd1);
    chk("rstfetch_timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = 8'h5A;
    @(posedge clk); #1; mem_ready = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("late_ready_req", 32'(mem_req), 32'd0);
      chk("late_ready_busdir", 32'(busdir), 32'd0);
    end
    do_read(23'h004123, 3, 1'b1, 1'b0, 1'b0);   // cache was cleared by reset
    gap(1'b0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
